prim_timer_ctrl: RTL
====================

PRIM_TIMER_CTRL -- requirements
Module: prim_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the width of the tick counter and period register.
REQ-002 SHALL have parameter PSC_WIDTH, default 8, the width of the prescaler.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port i_start, input, 1, a one-cycle pulse that starts or restarts the timer.
REQ-006 SHALL have port i_stop, input, 1, a one-cycle pulse that aborts the timer.
REQ-007 SHALL have port i_mode, input, 1, where 0 selects one-shot and 1 selects periodic.
REQ-008 SHALL have port i_period, input, WIDTH, the terminal count.
REQ-009 SHALL have port i_prescale, input, PSC_WIDTH, the divide value; the tick rate is clk/(i_prescale+1).
REQ-010 SHALL have port i_irq_ack, input, 1, which clears o_irq.
REQ-011 SHALL have port o_count, output, WIDTH, the current tick count.
REQ-012 SHALL have port o_busy, output, 1, which is high in state RUN.
REQ-013 SHALL have port o_irq, output, 1, a sticky expiry interrupt.
REQ-014 SHALL have port o_state, output, 2, the FSM state: IDLE=0, RUN=1, DONE=2.

Function
REQ-015 SHALL latch i_mode, i_period and i_prescale on an accepted i_start; later changes to these inputs have no effect until the next start.
REQ-016 SHALL implement a three-state FSM with states IDLE, RUN and DONE; encoding 3 is unreachable and SHALL recover to IDLE on the next edge.
REQ-017 SHALL, on i_start in any state with i_stop low, enter RUN, clear o_count to 0 and clear the prescaler to 0 on the same edge.
REQ-018 SHALL, on i_stop in RUN, enter IDLE with o_count held; in IDLE or DONE, i_stop SHALL have no effect.
REQ-019 SHALL give i_stop priority when i_start and i_stop are high together: the next state is IDLE and no restart occurs.
REQ-020 SHALL, in RUN, increment the prescaler each cycle; a tick SHALL occur when prescaler == latched prescale, and the prescaler SHALL wrap to 0 on that tick.
REQ-021 SHALL, on a tick with o_count != latched period, increment o_count by 1 (modulo 2^WIDTH); without a tick, o_count SHALL hold.
REQ-022 SHALL treat a tick with o_count == latched period as expiry, setting o_irq on that edge.
REQ-023 SHALL, on expiry in periodic mode, clear o_count to 0 and stay in RUN.
REQ-024 SHALL, on expiry in one-shot mode, hold o_count at the period and enter DONE.
REQ-025 SHALL, after a start at edge N, produce the first expiry at edge N+(P+1)*(S+1), where P is the latched period and S is the latched prescale; periodic expiries SHALL repeat every (P+1)*(S+1) cycles.
REQ-026 SHALL, with P=0 in periodic mode, expire on every tick with o_count held at 0.
REQ-027 SHALL clear o_irq on i_irq_ack; if an expiry and i_irq_ack occur on the same edge, o_irq SHALL remain 1.
REQ-028 SHALL leave o_irq unaffected by i_start and i_stop.
REQ-029 SHALL keep o_state, o_busy, o_count and o_irq registered, with no combinational path from any input to any output.
REQ-030 SHALL hold all state in IDLE and DONE apart from the o_irq clear.

Reset
REQ-031 SHALL, on an edge with i_rstn=0, set o_state=IDLE, o_busy=0, o_count=0, o_irq=0, prescaler=0 and the latched mode, period and prescale to 0.
REQ-032 SHALL let reset override every other input, including a reset asserted mid-RUN or in the same cycle as i_start.
REQ-033 SHALL have no asynchronous path: i_rstn is sampled only at i_clk rising edges.

Verification
REQ-034 SHALL cover: one-shot, P=3, S=0, start at edge 0 -> o_count 1,2,3 at edges 1-3; o_irq=1 and DONE at edge 4; o_count stays 3.
REQ-035 SHALL cover: periodic, P=2, S=1 -> expiries at edges 6, 12, 18; o_count sequence 0,0,1,1,2,2,0 repeating.
REQ-036 SHALL cover: i_irq_ack coinciding with an expiry -> o_irq stays 1; a lone ack one cycle later -> o_irq=0 at the next edge.
REQ-037 SHALL cover: i_start and i_stop together in RUN -> IDLE, o_count held, no expiry afterwards.
REQ-038 SHALL cover: i_rstn=0 for one cycle mid-RUN with o_irq=1 -> all outputs 0 and IDLE at that edge; a later i_start restarts from 0.
REQ-039 SHALL cover: i_start re-issued in RUN at o_count=5, P=9 -> o_count 0 at that edge; expiry (P+1)*(S+1) cycles later.

Source files
------------

// File: rtl/prim_timer_ctrl.sv
// prim_timer_ctrl: prescaled tick timer with one-shot and periodic modes.
// A start pulse latches mode/period/prescale and runs the counter. The counter
// advances once per prescaled tick. Each expiry sets a sticky interrupt, which
// is cleared by an acknowledge. All outputs come straight from flops.
module prim_timer_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PSC_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic                 i_mode,
  input  logic [WIDTH-1:0]     i_period,
  input  logic [PSC_WIDTH-1:0] i_prescale,
  input  logic                 i_irq_ack,
  output logic [WIDTH-1:0]     o_count,
  output logic                 o_busy,
  output logic                 o_irq,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_r;
  state_e                 state_s;
  logic [WIDTH-1:0]       count_r;
  logic [WIDTH-1:0]       count_s;
  logic [WIDTH-1:0]       period_r;
  logic [WIDTH-1:0]       period_s;
  logic [PSC_WIDTH-1:0]   psc_r;
  logic [PSC_WIDTH-1:0]   psc_s;
  logic [PSC_WIDTH-1:0]   prescale_r;
  logic [PSC_WIDTH-1:0]   prescale_s;
  logic                   mode_r;
  logic                   mode_s;
  logic                   irq_r;
  logic                   irq_s;
  logic                   busy_r;

  // Next-state, counter, prescaler, latched configuration and interrupt logic.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    psc_s      = psc_r;
    period_s   = period_r;
    prescale_s = prescale_r;
    mode_s     = mode_r;

    // Ack clears the interrupt; an expiry on the same edge re-sets it below.
    if (i_irq_ack) begin
      irq_s = 1'b0;
    end else begin
      irq_s = irq_r;
    end

    if (i_stop) begin
      // Stop wins over start. It only aborts a running timer; the
      // unreachable encoding is steered back to IDLE as well.
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_DONE: state_s = ST_DONE;
        default: state_s = ST_IDLE;
      endcase
    end else if (i_start) begin
      state_s    = ST_RUN;
      count_s    = {WIDTH{1'b0}};
      psc_s      = {PSC_WIDTH{1'b0}};
      period_s   = i_period;
      prescale_s = i_prescale;
      mode_s     = i_mode;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_DONE: state_s = ST_DONE;
        ST_RUN: begin
          if (psc_r == prescale_r) begin
            psc_s = {PSC_WIDTH{1'b0}};
            if (count_r == period_r) begin
              irq_s = 1'b1;
              if (mode_r) begin
                count_s = {WIDTH{1'b0}};
              end else begin
                state_s = ST_DONE;
              end
            end else begin
              count_s = count_r + WIDTH'(1);
            end
          end else begin
            psc_s = psc_r + PSC_WIDTH'(1);
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_r    <= ST_IDLE;
      count_r    <= {WIDTH{1'b0}};
      psc_r      <= {PSC_WIDTH{1'b0}};
      period_r   <= {WIDTH{1'b0}};
      prescale_r <= {PSC_WIDTH{1'b0}};
      mode_r     <= 1'b0;
      irq_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      psc_r      <= psc_s;
      period_r   <= period_s;
      prescale_r <= prescale_s;
      mode_r     <= mode_s;
      irq_r      <= irq_s;
      busy_r     <= (state_s == ST_RUN);
    end
  end

  assign o_state = state_r;
  assign o_busy  = busy_r;
  assign o_count = count_r;
  assign o_irq   = irq_r;

endmodule
